// File: rtl/hangman_judge.sv
// Round-play engine for the hangman game: holds the secret word, judges letter
// guesses, and drives start/win/lost toward the game status FSM.
module hangman_judge #(
    parameter int WORD_LEN  = 4,
    parameter int MAX_WRONG = 6
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [1:0]              current_state,
    input  logic                    load_word,
    input  logic [5*WORD_LEN-1:0]   word_in,
    input  logic                    start_req,
    input  logic                    guess_valid,
    input  logic [4:0]              guess_letter,
    output logic                    start_game,
    output logic                    win_game,
    output logic                    lost_game,
    output logic                    guess_ack,
    output logic [1:0]              guess_result,
    output logic [WORD_LEN-1:0]     revealed_mask,
    output logic [3:0]              wrong_count
);

    // phase    | meaning
    // PH_PLAY  | round in progress, guesses are judged
    // PH_WON   | every position revealed, guesses ignored
    // PH_LOST  | wrong-guess limit reached, guesses ignored
    typedef enum logic [1:0] {PH_PLAY, PH_WON, PH_LOST} phase_e;

    localparam logic [1:0] ST_START  = 2'd0;
    localparam logic [1:0] ST_INGAME = 2'd1;

    localparam logic [1:0] RES_MISS    = 2'd0;
    localparam logic [1:0] RES_HIT     = 2'd1;
    localparam logic [1:0] RES_REPEAT  = 2'd2;
    localparam logic [1:0] RES_INVALID = 2'd3;

    localparam logic [3:0] MAX_WRONG_C = 4'(MAX_WRONG);

    logic [5*WORD_LEN-1:0] word_q, word_d;
    logic                  word_ok_q, word_ok_d;
    logic                  start_req_q, start_req_d;
    logic                  start_game_q, start_game_d;
    logic [25:0]           used_q, used_d;
    logic [WORD_LEN-1:0]   mask_q, mask_d;
    logic [3:0]            wrong_q, wrong_d;
    phase_e                phase_q, phase_d;
    logic                  ack_q, ack_d;
    logic [1:0]            result_q, result_d;
    logic                  win_q, win_d;
    logic                  lost_q, lost_d;

    logic                  word_in_ok;
    logic                  letter_ok;
    logic [4:0]            letter_idx;
    logic [25:0]           letter_oh;
    logic [WORD_LEN-1:0]   match;
    logic                  in_start;
    logic                  in_game;

    assign in_start   = (current_state == ST_START);
    assign in_game    = (current_state == ST_INGAME);
    assign letter_ok  = (guess_letter != 5'd0) && (guess_letter <= 5'd26);
    assign letter_idx = guess_letter - 5'd1;
    assign letter_oh  = 26'd1 << letter_idx;

    always_comb begin
        word_in_ok = 1'b1;
        match      = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if ((word_in[5*i +: 5] == 5'd0) || (word_in[5*i +: 5] > 5'd26))
                word_in_ok = 1'b0;
            match[i] = (word_q[5*i +: 5] == guess_letter);
        end
    end

    always_comb begin
        word_d       = word_q;
        word_ok_d    = word_ok_q;
        start_req_d  = start_req;
        start_game_d = 1'b0;
        used_d       = used_q;
        mask_d       = mask_q;
        wrong_d      = wrong_q;
        phase_d      = phase_q;
        ack_d        = 1'b0;
        result_d     = result_q;

        if (in_start && load_word) begin
            word_d    = word_in;
            word_ok_d = word_in_ok;
        end

        // word_ok_q is the pre-load value when a load and an edge coincide
        if (in_start && start_req && !start_req_q && word_ok_q)
            start_game_d = 1'b1;

        if (in_start) begin
            mask_d  = '0;
            wrong_d = 4'd0;
            used_d  = '0;
            phase_d = PH_PLAY;
        end else if (in_game && (phase_q == PH_PLAY) && guess_valid) begin
            ack_d = 1'b1;
            if (!letter_ok) begin
                result_d = RES_INVALID;
            end else if (|(used_q & letter_oh)) begin
                result_d = RES_REPEAT;
            end else if (|match) begin
                result_d = RES_HIT;
                mask_d   = mask_q | match;
                used_d   = used_q | letter_oh;
            end else begin
                result_d = RES_MISS;
                used_d   = used_q | letter_oh;
                if (wrong_q < MAX_WRONG_C)
                    wrong_d = wrong_q + 4'd1;
            end

            if (&mask_d)
                phase_d = PH_WON;
            else if (wrong_d >= MAX_WRONG_C)
                phase_d = PH_LOST;
        end

        // look at phase_d so the result flags rise together with the ack
        win_d  = (phase_d == PH_WON)  && in_game;
        lost_d = (phase_d == PH_LOST) && in_game;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_q       <= '0;
            word_ok_q    <= 1'b0;
            start_req_q  <= 1'b0;
            start_game_q <= 1'b0;
            used_q       <= '0;
            mask_q       <= '0;
            wrong_q      <= 4'd0;
            phase_q      <= PH_PLAY;
            ack_q        <= 1'b0;
            result_q     <= 2'd0;
            win_q        <= 1'b0;
            lost_q       <= 1'b0;
        end else begin
            word_q       <= word_d;
            word_ok_q    <= word_ok_d;
            start_req_q  <= start_req_d;
            start_game_q <= start_game_d;
            used_q       <= used_d;
            mask_q       <= mask_d;
            wrong_q      <= wrong_d;
            phase_q      <= phase_d;
            ack_q        <= ack_d;
            result_q     <= result_d;
            win_q        <= win_d;
            lost_q       <= lost_d;
        end
    end

    assign start_game    = start_game_q;
    assign win_game      = win_q;
    assign lost_game     = lost_q;
    assign guess_ack     = ack_q;
    assign guess_result  = result_q;
    assign revealed_mask = mask_q;
    assign wrong_count   = wrong_q;

endmodule

// File: tb/tb_hangman_judge.sv
// Directed bench for hangman_judge; the bench plays the status FSM by driving
// current_state directly.
module tb_hangman_judge;

    localparam int WL = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic [1:0]    current_state;
    logic          load_word;
    logic [5*WL-1:0] word_in;
    logic          start_req;
    logic          guess_valid;
    logic [4:0]    guess_letter;
    logic          start_game, win_game, lost_game, guess_ack;
    logic [1:0]    guess_result;
    logic [WL-1:0] revealed_mask;
    logic [3:0]    wrong_count;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] S_START = 2'd0, S_INGAME = 2'd1, S_WIN = 2'd2, S_LOST = 2'd3;
    localparam logic [1:0] R_MISS = 2'd0, R_HIT = 2'd1, R_REPEAT = 2'd2, R_INVALID = 2'd3;

    localparam logic [5*WL-1:0] W_CODE = {5'd5, 5'd4, 5'd15, 5'd3};
    localparam logic [5*WL-1:0] W_BOOK = {5'd11, 5'd15, 5'd15, 5'd2};
    localparam logic [5*WL-1:0] W_BAD  = {5'd11, 5'd15, 5'd0, 5'd2};

    hangman_judge #(.WORD_LEN(WL), .MAX_WRONG(6)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .current_state (current_state),
        .load_word     (load_word),
        .word_in       (word_in),
        .start_req     (start_req),
        .guess_valid   (guess_valid),
        .guess_letter  (guess_letter),
        .start_game    (start_game),
        .win_game      (win_game),
        .lost_game     (lost_game),
        .guess_ack     (guess_ack),
        .guess_result  (guess_result),
        .revealed_mask (revealed_mask),
        .wrong_count   (wrong_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic guess(input logic [4:0] letter);
        guess_valid  = 1'b1;
        guess_letter = letter;
        tick();
        guess_valid  = 1'b0;
        guess_letter = 5'd0;
    endtask

    task automatic load(input logic [5*WL-1:0] w);
        load_word = 1'b1;
        word_in   = w;
        tick();
        load_word = 1'b0;
    endtask

    task automatic check_guess(input string tag, input logic [1:0] res,
                               input logic [WL-1:0] mask, input logic [3:0] wc);
        check_eq({tag, "_ack"},   32'(guess_ack), 32'd1);
        check_eq({tag, "_res"},   32'(guess_result), 32'(res));
        check_eq({tag, "_mask"},  32'(revealed_mask), 32'(mask));
        check_eq({tag, "_wrong"}, 32'(wrong_count), 32'(wc));
    endtask

    initial begin : stim
        int pulses;
        logic [4:0] misses [6];
        misses = '{5'd26, 5'd24, 5'd17, 5'd10, 5'd22, 5'd23};

        resetn        = 1'b0;
        current_state = S_START;
        load_word     = 1'b0;
        word_in       = '0;
        start_req     = 1'b0;
        guess_valid   = 1'b0;
        guess_letter  = 5'd0;
        #12;
        check_eq("rst_start", 32'(start_game), 32'd0);
        check_eq("rst_win",   32'(win_game), 32'd0);
        check_eq("rst_lost",  32'(lost_game), 32'd0);
        check_eq("rst_ack",   32'(guess_ack), 32'd0);
        check_eq("rst_res",   32'(guess_result), 32'd0);
        check_eq("rst_mask",  32'(revealed_mask), 32'd0);
        check_eq("rst_wrong", 32'(wrong_count), 32'd0);
        resetn = 1'b1;
        tick();

        // good word, start_req held 5 cycles -> one pulse
        load(W_CODE);
        start_req = 1'b1;
        tick();
        check_eq("start_first", 32'(start_game), 32'd1);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (start_game) pulses++;
        end
        check_eq("start_held_extra", 32'(pulses), 32'd0);
        start_req = 1'b0;
        tick();

        // BOOK round to a win
        load(W_BOOK);
        current_state = S_INGAME;
        tick();
        guess(5'd15);
        check_guess("hit_o", R_HIT, 4'b0110, 4'd0);
        guess(5'd15);
        check_guess("rep_o", R_REPEAT, 4'b0110, 4'd0);
        check_eq("rep_o_win", 32'(win_game), 32'd0);
        guess(5'd2);
        check_guess("hit_b", R_HIT, 4'b0111, 4'd0);
        guess(5'd11);
        check_guess("hit_k", R_HIT, 4'b1111, 4'd0);
        check_eq("win_with_ack", 32'(win_game), 32'd1);
        check_eq("win_not_lost", 32'(lost_game), 32'd0);
        tick();
        check_eq("win_held", 32'(win_game), 32'd1);
        check_eq("ack_one_cycle", 32'(guess_ack), 32'd0);
        guess(5'd1);
        check_eq("won_guess_noack", 32'(guess_ack), 32'd0);
        current_state = S_WIN;
        tick();
        check_eq("win_drop", 32'(win_game), 32'd0);

        // new round: invalid codes then six misses
        current_state = S_START;
        tick();
        check_eq("clr_mask", 32'(revealed_mask), 32'd0);
        current_state = S_INGAME;
        tick();
        guess(5'd0);
        check_guess("inv_0", R_INVALID, 4'b0000, 4'd0);
        guess(5'd27);
        check_guess("inv_27", R_INVALID, 4'b0000, 4'd0);
        for (int i = 0; i < 6; i++) begin
            guess(misses[i]);
            check_guess($sformatf("miss%0d", i + 1), R_MISS, 4'b0000, 4'(i + 1));
            check_eq($sformatf("miss%0d_lost", i + 1), 32'(lost_game), (i == 5) ? 32'd1 : 32'd0);
        end
        check_eq("lost_not_win", 32'(win_game), 32'd0);
        guess(5'd25);
        check_eq("lost_guess_noack", 32'(guess_ack), 32'd0);
        check_eq("lost_count_sat", 32'(wrong_count), 32'd6);
        check_eq("lost_held", 32'(lost_game), 32'd1);
        current_state = S_LOST;
        tick();
        check_eq("lost_drop", 32'(lost_game), 32'd0);

        // bad word: no start; guesses in START ignored
        current_state = S_START;
        tick();
        load(W_BAD);
        start_req = 1'b1;
        tick();
        check_eq("bad_word_nostart", 32'(start_game), 32'd0);
        start_req = 1'b0;
        tick();
        guess(5'd2);
        check_eq("start_guess_noack", 32'(guess_ack), 32'd0);

        // load and edge together use the old (bad) word_ok
        load_word = 1'b1;
        word_in   = W_CODE;
        start_req = 1'b1;
        tick();
        load_word = 1'b0;
        check_eq("load_edge_same", 32'(start_game), 32'd0);
        tick();
        check_eq("load_edge_held", 32'(start_game), 32'd0);
        start_req = 1'b0;
        tick();
        start_req = 1'b1;
        tick();
        check_eq("restart_pulse", 32'(start_game), 32'd1);
        start_req = 1'b0;
        tick();

        // status back to START clears the used set too
        load(W_BOOK);
        current_state = S_INGAME;
        tick();
        guess(5'd15);
        check_guess("r2_hit_o", R_HIT, 4'b0110, 4'd0);
        guess(5'd26);
        check_guess("r2_miss_z", R_MISS, 4'b0110, 4'd1);
        current_state = S_START;
        tick();
        check_eq("r2_clr_mask", 32'(revealed_mask), 32'd0);
        check_eq("r2_clr_wrong", 32'(wrong_count), 32'd0);
        current_state = S_INGAME;
        tick();
        guess(5'd15);
        check_guess("r3_hit_o", R_HIT, 4'b0110, 4'd0);
        guess(5'd2);
        check_guess("r3_hit_b", R_HIT, 4'b0111, 4'd0);
        guess(5'd26);
        check_guess("r3_miss_z", R_MISS, 4'b0111, 4'd1);

        // asynchronous reset mid-round
        #2;
        resetn = 1'b0;
        #1;
        check_eq("arst_mask",  32'(revealed_mask), 32'd0);
        check_eq("arst_wrong", 32'(wrong_count), 32'd0);
        check_eq("arst_win",   32'(win_game), 32'd0);
        check_eq("arst_lost",  32'(lost_game), 32'd0);
        check_eq("arst_ack",   32'(guess_ack), 32'd0);
        #3;
        resetn        = 1'b1;
        current_state = S_START;
        tick();
        tick();
        check_eq("arst_no_start", 32'(start_game), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
